// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes and FSM state type for the load/store memory access controller.
package mem_ctrl_pkg;

    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: decodes LDR/STR, runs a req/ready RAM handshake, stalls via busy.
// Optional macro MEM_TIMEOUT_EN adds a TIMEOUT_CYC wait limit that aborts with an err pulse.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned OP_W        = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              ram_req,
    output logic              rw_out,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              add_bus_sel,
    output logic              ldr_sel,
    output logic [DATA_W-1:0] rdata,
    output logic              ld_valid,
    output logic              st_done,
    output logic              busy,
    output logic              err
);

    state_t state, state_n;

    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_wdata_n;
    logic [DATA_W-1:0] rdata_n;
    logic              ld_done_n;
    logic              st_done_n;
    logic              err_n;
    logic              access_n;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             expired;
    assign expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    always_comb begin
        state_n     = state;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        rdata_n     = rdata;
        ld_done_n   = 1'b0;
        st_done_n   = 1'b0;
        err_n       = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_n  = '0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (op_valid && opcode == OP_W'(OP_LDR)) begin
                    ram_addr_n = addr;
                    state_n    = ST_RD;
                end else if (op_valid && opcode == OP_W'(OP_STR)) begin
                    ram_addr_n  = addr;
                    ram_wdata_n = wdata;
                    state_n     = ST_WR;
                end
            end
            ST_RD, ST_WR: begin
                if (ram_ready) begin
                    state_n = ST_DONE;
                    if (state == ST_RD) begin
                        rdata_n   = ram_rdata;
                        ld_done_n = 1'b1;
                    end else begin
                        st_done_n = 1'b1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (expired) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b1;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
`endif
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        access_n = (state_n == ST_RD) || (state_n == ST_WR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ram_req     <= 1'b0;
            rw_out      <= 1'b1;
            add_bus_sel <= 1'b0;
            busy        <= 1'b0;
            ldr_sel     <= 1'b0;
            ld_valid    <= 1'b0;
            st_done     <= 1'b0;
            err         <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            rdata       <= '0;
        end else begin
            state       <= state_n;
            ram_req     <= access_n;
            rw_out      <= (state_n != ST_WR);
            add_bus_sel <= access_n;
            busy        <= access_n;
            ldr_sel     <= ld_done_n;
            ld_valid    <= ld_done_n;
            st_done     <= st_done_n;
            err         <= err_n;
            ram_addr    <= ram_addr_n;
            ram_wdata   <= ram_wdata_n;
            rdata       <= rdata_n;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) wait_cnt <= '0;
        else     wait_cnt <= wait_cnt_n;
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl; exercises the MEM_TIMEOUT_EN path when that macro is defined.
module tb_mem_access_ctrl;

    localparam logic [3:0] LDR = 4'b1001;
    localparam logic [3:0] STR = 4'b1010;
    localparam logic [7:0] IDLE_VEC = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  opcode;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] ram_rdata;
    logic        ram_ready;
    logic        ram_req, rw_out, add_bus_sel, ldr_sel, ld_valid, st_done, busy, err;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_rdata = '0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .OP_W(4), .ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .addr(addr),
        .wdata(wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .ram_req(ram_req), .rw_out(rw_out), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .add_bus_sel(add_bus_sel), .ldr_sel(ldr_sel), .rdata(rdata), .ld_valid(ld_valid),
        .st_done(st_done), .busy(busy), .err(err)
    );

    // {ram_req, busy, rw_out, add_bus_sel, ldr_sel, ld_valid, st_done, err}
    function automatic logic [7:0] outs();
        return {ram_req, busy, rw_out, add_bus_sel, ldr_sel, ld_valid, st_done, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: a legal op gives waits+1 request cycles, one done cycle, then idle.
    task automatic run_txn(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d,
                           input int unsigned waits, input logic [15:0] rd, input bit noise,
                           input string tag);
        bit is_ld, is_st;
        logic [7:0] exp;
        is_ld = (op == LDR);
        is_st = (op == STR);
        op_valid = 1'b1; opcode = op; addr = a; wdata = d;
        step();
        if (!is_ld && !is_st) begin
            op_valid = 1'b0;
            n_checks++;
            if (outs() !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL %s illegal-op outs got=%b exp=%b", tag, outs(), IDLE_VEC);
            end
            step();
            n_checks++;
            if (outs() !== IDLE_VEC) begin
                n_fail++;
                $display("FAIL %s illegal-op hold outs got=%b exp=%b", tag, outs(), IDLE_VEC);
            end
            return;
        end
        for (int unsigned k = 0; k <= waits; k++) begin
            op_valid = noise; opcode = LDR; addr = 8'($urandom); wdata = 16'($urandom);
            exp = {1'b1, 1'b1, is_ld, 1'b1, 4'b0000};
            n_checks++;
            if (outs() !== exp || ram_addr !== a || (is_st && ram_wdata !== d)) begin
                n_fail++;
                $display("FAIL %s wait%0d outs got=%b exp=%b addr got=%h exp=%h wdata got=%h exp=%h",
                         tag, k, outs(), exp, ram_addr, a, ram_wdata, is_st ? d : ram_wdata);
            end
            ram_ready = (k == waits);
            ram_rdata = (k == waits) ? rd : 16'($urandom);
            step();
        end
        ram_ready = 1'b0; ram_rdata = 16'($urandom);
        if (is_ld) exp_rdata = rd;
        exp = {1'b0, 1'b0, 1'b1, 1'b0, is_ld, is_ld, is_st, 1'b0};
        n_checks++;
        if (outs() !== exp || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s done outs got=%b exp=%b rdata got=%h exp=%h",
                     tag, outs(), exp, rdata, exp_rdata);
        end
        step();
        op_valid = 1'b0;
        n_checks++;
        if (outs() !== IDLE_VEC || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s post-done outs got=%b exp=%b rdata got=%h exp=%h",
                     tag, outs(), IDLE_VEC, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; opcode = '0; addr = '0; wdata = '0;
        ram_rdata = '0; ram_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (outs() !== IDLE_VEC || ram_addr !== 8'h00 || ram_wdata !== 16'h0 || rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset outs got=%b exp=%b addr=%h wdata=%h rdata=%h (exp zeros)",
                     outs(), IDLE_VEC, ram_addr, ram_wdata, rdata);
        end
        exp_rdata = '0;
    endtask

    task automatic test_ldr();
        run_txn(LDR, 8'h10, 16'h0000, 0, 16'hBEEF, 1'b0, "ldr_zero_wait");
    endtask

    task automatic test_str();
        run_txn(STR, 8'h20, 16'h1234, 3, 16'h0000, 1'b0, "str_three_wait");
    endtask

    task automatic test_illegal_op();
        run_txn(4'b0001, 8'h33, 16'h5555, 0, 16'h0, 1'b0, "illegal_0001");
    endtask

    task automatic test_back_to_back();
        run_txn(LDR, 8'h44, 16'h0, 2, 16'hCAFE, 1'b1, "ldr_during_rd");
        run_txn(STR, 8'h45, 16'hA5A5, 1, 16'h0, 1'b1, "ldr_during_wr");
    endtask

    task automatic test_rst_mid_wr();
        op_valid = 1'b1; opcode = STR; addr = 8'h77; wdata = 16'h9999;
        step();
        op_valid = 1'b0;
        step();
        n_checks++;
        if (rw_out !== 1'b0 || ram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wr pre rw_out got=%b exp=0 ram_req got=%b exp=1", rw_out, ram_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (outs() !== IDLE_VEC || ram_addr !== 8'h00 || ram_wdata !== 16'h0 || rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_wr abort outs got=%b exp=%b addr=%h wdata=%h rdata=%h",
                     outs(), IDLE_VEC, ram_addr, ram_wdata, rdata);
        end
        exp_rdata = '0;
        ram_ready = 1'b1;
        step();
        ram_ready = 1'b0;
        n_checks++;
        if (outs() !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL rst_mid_wr after outs got=%b exp=%b", outs(), IDLE_VEC);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        op_valid = 1'b1; opcode = LDR; addr = 8'h5A;
        step();
        op_valid = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            n_checks++;
            if (outs() !== 8'b1111_0000) begin
                n_fail++;
                $display("FAIL timeout wait%0d outs got=%b exp=%b", k, outs(), 8'b1111_0000);
            end
            step();
        end
        n_checks++;
        if (outs() !== 8'b0010_0001) begin
            n_fail++;
            $display("FAIL timeout err outs got=%b exp=%b", outs(), 8'b0010_0001);
        end
        step();
        n_checks++;
        if (outs() !== IDLE_VEC || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL timeout after outs got=%b exp=%b rdata got=%h exp=%h",
                     outs(), IDLE_VEC, rdata, exp_rdata);
        end
    endtask
`else
    task automatic test_long_wait();
        run_txn(LDR, 8'hE1, 16'h0, 12, 16'h7E57, 1'b0, "ldr_long_wait");
    endtask
`endif

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: op = LDR;
                1: op = STR;
                default: begin
                    op = 4'($urandom);
                    while (op == LDR || op == STR) op = 4'($urandom);
                end
            endcase
            run_txn(op, 8'($urandom), 16'($urandom), $urandom_range(0, 3), 16'($urandom),
                    1'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_illegal_op();
        test_back_to_back();
        test_rst_mid_wr();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
